sreg_dreg_one_hot: RTL and testbench
====================================

Name: sreg_dreg_one_hot

Overview:
Registered source/destination register selector for the GSU register file. It tracks the TO/FROM/WITH prefix state and drives one-hot read-mux (Sreg) and write-enable (Dreg) selects. It is a parametrised successor to the fixed 3-to-8 one-hot decoder, and it adds prefix latching, auto-revert to the default register after each non-prefix instruction, a B flag, and range checking. It sits between the instruction decoder and the register file.

Parameters:
NUM_REGS, 16, number of general registers; any value 2..256, not necessarily a power of two
SEL_W, 4, width of register number fields; must satisfy 2**SEL_W >= NUM_REGS
DEFAULT_REG, 0, register index that Sreg/Dreg revert to (R0)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
prefix_valid  in  1  a prefix instruction retires this cycle
prefix_op  in  2  00 reserved, 01 TO, 10 FROM, 11 WITH
reg_num  in  SEL_W  register operand of the prefix
instr_done  in  1  a non-prefix instruction retires this cycle
flush  in  1  synchronous clear of prefix state (GO cleared / pipeline flush)
src_num  out  SEL_W  current Sreg index
dst_num  out  SEL_W  current Dreg index
src_sel  out  NUM_REGS  one-hot of src_num
dst_sel  out  NUM_REGS  one-hot of dst_num
b_flag  out  1  WITH prefix active
sel_err  out  1  one-cycle pulse when a prefix carries reg_num >= NUM_REGS

Behaviour:
- Reset (rst_n low, asynchronous): src_num = dst_num = DEFAULT_REG, src_sel = dst_sel = one-hot(DEFAULT_REG), b_flag = 0, sel_err = 0.
- All outputs are registered. Latency is 1 cycle from an input event to the visible select.
- src_sel and dst_sel always have exactly one bit set. They are registered alongside src_num and dst_num, never decoded combinationally at the output.
- State update, in priority order, evaluated each rising edge:
  1. flush = 1: src = dst = DEFAULT_REG and b_flag = 0. Any prefix_valid or instr_done in the same cycle is ignored.
  2. prefix_valid = 1 with reg_num < NUM_REGS:
     - TO: dst = reg_num; src and b_flag unchanged.
     - FROM: src = reg_num; dst and b_flag unchanged.
     - WITH: src = dst = reg_num, b_flag = 1.
     - op 00: no change.
     - A simultaneous instr_done is ignored, because the prefix is itself the retiring instruction.
  3. prefix_valid = 1 with reg_num >= NUM_REGS: state unchanged and sel_err = 1 for exactly one cycle. Op 00 does not raise sel_err.
  4. instr_done = 1 (no prefix): src = dst = DEFAULT_REG, b_flag = 0.
  5. Otherwise: hold.
- Consecutive prefixes accumulate, for example FROM R3 then TO R5 gives src = 3, dst = 5. A later WITH overrides both and sets b_flag.
- A TO or FROM after a WITH leaves b_flag set. Interpreting TO/FROM as MOVE while B is set happens upstream; this block only updates src/dst as stated.
- sel_err is 0 in every cycle without an out-of-range prefix.
- If rst_n is asserted mid-sequence, all prefix state is lost immediately and the outputs return to their reset values without waiting for a clock edge.

Decomposition:
- Shared include superfx_defs.vh holds:
  - PREFIX_NONE/TO/FROM/WITH 2-bit codes.
  - Default NUM_REGS = 16.
  - DEFAULT_REG = 0.
- Sub-module one_hot_decoder (parameters WIDTH_IN and NUM_OUT) is a combinational binary-to-one-hot decoder; an out-of-range input gives all zeros. It is instantiated twice to generate the next-state values of src_sel and dst_sel before the registers. It is the generalised replacement for the fixed 3-bit decoder.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high -> src_num = dst_num = 0, src_sel = dst_sel = 16'h0001, b_flag = 0, sel_err = 0.
- Prefix accumulation: FROM R3, then TO R5, then instr_done -> src_sel = 16'h0008 after the first edge; dst_sel = 16'h0020 after the second; both 16'h0001 one cycle after instr_done.
- WITH semantics: WITH R12 -> src_num = dst_num = 12, both selects = 16'h1000, b_flag = 1. Then TO R2 -> dst_num = 2, src_num = 12, b_flag = 1. Then instr_done -> all defaults, b_flag = 0.
- Simultaneous events: prefix_valid(TO R7) with instr_done in the same cycle -> dst_num = 7, state not cleared. flush with prefix_valid(WITH R9) -> all defaults, b_flag = 0.
- Range check at NUM_REGS = 12: FROM R13 -> state unchanged and sel_err high for exactly 1 cycle. FROM R11 -> src_sel = 12'h800, sel_err = 0.
- Async reset mid-operation: WITH R4, then drop rst_n between edges -> outputs return to defaults before the next clk edge; no residual b_flag after release.

Source files
------------

// File: rtl/sreg_dreg_one_hot_pkg.sv
// Shared GSU register-select definitions: prefix opcodes and default sizing.
// No logic, no latency.
// No flow control; constants only.
package sreg_dreg_one_hot_pkg;

    localparam logic [1:0] PREFIX_NONE = 2'b00;
    localparam logic [1:0] PREFIX_TO   = 2'b01;
    localparam logic [1:0] PREFIX_FROM = 2'b10;
    localparam logic [1:0] PREFIX_WITH = 2'b11;

    localparam int DEF_NUM_REGS   = 16;
    localparam int DEF_DEFAULT_REG = 0;

endpackage

// File: rtl/sreg_dreg_one_hot_decoder.sv
// Binary-to-one-hot decoder; out-of-range input yields all zeros.
// Combinational, zero latency.
// No flow control.
module one_hot_decoder #(
    parameter int WIDTH_IN = 4,
    parameter int NUM_OUT  = 16
) (
    input  logic [WIDTH_IN-1:0] bin,
    output logic [NUM_OUT-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (int'(bin) == i) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/sreg_dreg_one_hot.sv
// GSU Sreg/Dreg selector: tracks TO/FROM/WITH prefixes, drives one-hot selects.
// 1-cycle latency from prefix/instr_done/flush to registered outputs.
// No backpressure; every retire/flush event is consumed in its cycle.
module sreg_dreg_one_hot
    import sreg_dreg_one_hot_pkg::*;
#(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int SEL_W       = 4,
    parameter int DEFAULT_REG = DEF_DEFAULT_REG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prefix_valid,
    input  logic [1:0]          prefix_op,
    input  logic [SEL_W-1:0]    reg_num,
    input  logic                instr_done,
    input  logic                flush,
    output logic [SEL_W-1:0]    src_num,
    output logic [SEL_W-1:0]    dst_num,
    output logic [NUM_REGS-1:0] src_sel,
    output logic [NUM_REGS-1:0] dst_sel,
    output logic                b_flag,
    output logic                sel_err
);

    localparam logic [SEL_W-1:0]    DEF_NUM = SEL_W'(DEFAULT_REG);
    localparam logic [NUM_REGS-1:0] DEF_SEL = NUM_REGS'(1) << DEFAULT_REG;

    logic [SEL_W-1:0]    src_nxt, dst_nxt;
    logic [NUM_REGS-1:0] src_sel_nxt, dst_sel_nxt;
    logic                b_nxt, err_nxt, in_range;

    assign in_range = int'(reg_num) < NUM_REGS;

    // A retiring prefix is itself the instruction, so it outranks instr_done.
    always_comb begin
        src_nxt = src_num;
        dst_nxt = dst_num;
        b_nxt   = b_flag;
        err_nxt = 1'b0;
        if (flush) begin
            src_nxt = DEF_NUM;
            dst_nxt = DEF_NUM;
            b_nxt   = 1'b0;
        end else if (prefix_valid) begin
            if (!in_range) begin
                err_nxt = (prefix_op != PREFIX_NONE);
            end else begin
                case (prefix_op)
                    PREFIX_TO:   dst_nxt = reg_num;
                    PREFIX_FROM: src_nxt = reg_num;
                    PREFIX_WITH: begin
                        src_nxt = reg_num;
                        dst_nxt = reg_num;
                        b_nxt   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (instr_done) begin
            src_nxt = DEF_NUM;
            dst_nxt = DEF_NUM;
            b_nxt   = 1'b0;
        end
    end

    one_hot_decoder #(.WIDTH_IN(SEL_W), .NUM_OUT(NUM_REGS)) u_src_dec (
        .bin    (src_nxt),
        .onehot (src_sel_nxt)
    );

    one_hot_decoder #(.WIDTH_IN(SEL_W), .NUM_OUT(NUM_REGS)) u_dst_dec (
        .bin    (dst_nxt),
        .onehot (dst_sel_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_num <= DEF_NUM;
            dst_num <= DEF_NUM;
            src_sel <= DEF_SEL;
            dst_sel <= DEF_SEL;
            b_flag  <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            src_num <= src_nxt;
            dst_num <= dst_nxt;
            src_sel <= src_sel_nxt;
            dst_sel <= dst_sel_nxt;
            b_flag  <= b_nxt;
            sel_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sreg_dreg_one_hot.sv
// Directed bench for sreg_dreg_one_hot: a 16-register and a 12-register instance
// share stimulus; expected values are hand-computed constants.
module tb_sreg_dreg_one_hot;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       prefix_valid = 1'b0;
    logic [1:0] prefix_op = 2'b00;
    logic [3:0] reg_num = 4'd0;
    logic       instr_done = 1'b0;
    logic       flush = 1'b0;

    logic [3:0]  a_src, a_dst, b_src, b_dst;
    logic [15:0] a_ssel, a_dsel;
    logic [11:0] b_ssel, b_dsel;
    logic        a_b, a_err, b_b, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sreg_dreg_one_hot #(.NUM_REGS(16), .SEL_W(4), .DEFAULT_REG(0)) dut16 (
        .clk(clk), .rst_n(rst_n), .prefix_valid(prefix_valid), .prefix_op(prefix_op),
        .reg_num(reg_num), .instr_done(instr_done), .flush(flush),
        .src_num(a_src), .dst_num(a_dst), .src_sel(a_ssel), .dst_sel(a_dsel),
        .b_flag(a_b), .sel_err(a_err)
    );

    sreg_dreg_one_hot #(.NUM_REGS(12), .SEL_W(4), .DEFAULT_REG(0)) dut12 (
        .clk(clk), .rst_n(rst_n), .prefix_valid(prefix_valid), .prefix_op(prefix_op),
        .reg_num(reg_num), .instr_done(instr_done), .flush(flush),
        .src_num(b_src), .dst_num(b_dst), .src_sel(b_ssel), .dst_sel(b_dsel),
        .b_flag(b_b), .sel_err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus, then return all inputs to idle.
    task automatic drive(input logic pv, input logic [1:0] op, input logic [3:0] rn,
                         input logic id, input logic fl);
        prefix_valid = pv;
        prefix_op    = op;
        reg_num      = rn;
        instr_done   = id;
        flush        = fl;
        cyc();
        prefix_valid = 1'b0;
        prefix_op    = 2'b00;
        reg_num      = 4'd0;
        instr_done   = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc();
        cyc();
        check("rst_hold_src_sel", a_ssel, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("rst_src_num", a_src, 0);
        check("rst_dst_num", a_dst, 0);
        check("rst_src_sel", a_ssel, 16'h0001);
        check("rst_dst_sel", a_dsel, 16'h0001);
        check("rst_b_flag", a_b, 0);
        check("rst_sel_err", a_err, 0);
        check("rst12_src_sel", b_ssel, 12'h001);

        // Prefix accumulation
        drive(1, 2'b10, 4'd3, 0, 0);
        check("from3_src_sel", a_ssel, 16'h0008);
        check("from3_dst_sel", a_dsel, 16'h0001);
        drive(1, 2'b01, 4'd5, 0, 0);
        check("to5_dst_sel", a_dsel, 16'h0020);
        check("to5_src_num", a_src, 3);
        cyc();
        check("idle_hold_dst", a_dst, 5);
        drive(0, 2'b00, 4'd0, 1, 0);
        check("done_src_sel", a_ssel, 16'h0001);
        check("done_dst_sel", a_dsel, 16'h0001);

        // WITH semantics; R12 is out of range for the 12-register instance
        drive(1, 2'b11, 4'd12, 0, 0);
        check("with12_src_num", a_src, 12);
        check("with12_dst_num", a_dst, 12);
        check("with12_src_sel", a_ssel, 16'h1000);
        check("with12_dst_sel", a_dsel, 16'h1000);
        check("with12_b_flag", a_b, 1);
        check("with12_err16", a_err, 0);
        check("with12_err12", b_err, 1);
        check("with12_b12", b_b, 0);
        drive(1, 2'b01, 4'd2, 0, 0);
        check("to2_dst_num", a_dst, 2);
        check("to2_src_num", a_src, 12);
        check("to2_b_flag", a_b, 1);
        check("to2_err12_cleared", b_err, 0);
        check("to2_dst12", b_dst, 2);
        drive(0, 2'b00, 4'd0, 1, 0);
        check("done2_src_num", a_src, 0);
        check("done2_dst_num", a_dst, 0);
        check("done2_b_flag", a_b, 0);

        // Simultaneous events
        drive(1, 2'b01, 4'd7, 1, 0);
        check("to7_done_dst", a_dst, 7);
        check("to7_done_dst_sel", a_dsel, 16'h0080);
        drive(1, 2'b11, 4'd9, 0, 1);
        check("flush_with_src", a_src, 0);
        check("flush_with_dst", a_dst, 0);
        check("flush_with_b", a_b, 0);
        check("flush_with_sel", a_dsel, 16'h0001);

        // Range check on the 12-register instance
        drive(1, 2'b10, 4'd13, 0, 0);
        check("from13_err12", b_err, 1);
        check("from13_src12", b_src, 0);
        check("from13_ssel12", b_ssel, 12'h001);
        check("from13_src16", a_src, 13);
        cyc();
        check("err12_one_cycle", b_err, 0);
        drive(1, 2'b10, 4'd11, 0, 0);
        check("from11_ssel12", b_ssel, 12'h800);
        check("from11_err12", b_err, 0);
        drive(1, 2'b00, 4'd15, 0, 0);
        check("op00_oor_err12", b_err, 0);
        check("op00_src12_hold", b_src, 11);
        check("op00_src16_hold", a_src, 11);

        // Async reset between edges
        drive(1, 2'b11, 4'd4, 0, 0);
        check("with4_b_flag", a_b, 1);
        check("with4_src_sel", a_ssel, 16'h0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_src_num", a_src, 0);
        check("arst_dst_sel", a_dsel, 16'h0001);
        check("arst_b_flag", a_b, 0);
        check("arst_b12", b_src, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("post_arst_b_flag", a_b, 0);
        check("post_arst_src_sel", a_ssel, 16'h0001);
        check("post_arst_err", a_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
